// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and framing constants for the instruction memory loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    DONE
  } state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_STEP      = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - little-endian byte-to-word shifter with position flags
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  data,
  output logic [31:0] next_word,
  output logic [15:0] length,
  output logic        len_last,
  output logic        word_last
);

  logic [1:0]  cnt;
  logic [31:0] word;

  // Newest byte enters at the top, so after four shifts the first byte sits in bits 7:0.
  assign next_word = {data, word[31:8]};
  // After only two shifts the length field occupies the upper half.
  assign length    = next_word[31:16];
  assign len_last  = shift && (cnt == 2'(LEN_BYTES - 1));
  assign word_last = shift && (cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      word <= '0;
    end else if (clear) begin
      cnt  <= '0;
      word <= '0;
    end else if (shift) begin
      cnt  <= cnt + 2'd1;
      word <= next_word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader writing packed words into instruction memory
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int Width = 32,
  parameter int Depth = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             we,
  output logic [Width-1:0] waddr,
  output logic [Width-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             cpu_hold
);

  localparam int MAX_WORDS = Depth / BYTES_PER_WORD;

  state_t      state;
  logic [15:0] n_words;
  logic [15:0] word_idx;
  logic        take;
  logic        start_ok;
  logic        len_done;
  logic [31:0] pk_word;
  logic [15:0] pk_len;
  logic        pk_len_last;
  logic        pk_word_last;

  assign take     = byte_valid && byte_ready;
  assign start_ok = start && (state == IDLE || state == DONE);
  assign len_done = (state == LEN) && pk_len_last;

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_ok || len_done),
    .shift     (take),
    .data      (byte_data),
    .next_word (pk_word),
    .length    (pk_len),
    .len_last  (pk_len_last),
    .word_last (pk_word_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      n_words    <= '0;
      word_idx   <= '0;
      byte_ready <= 1'b0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LEN;
            done       <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b1;
            byte_ready <= 1'b1;
            cpu_hold   <= 1'b1;
            waddr      <= '0;
            word_idx   <= '0;
          end
        end
        LEN: begin
          if (len_done) begin
            n_words <= pk_len;
            if (pk_len == 16'd0) begin
              state      <= DONE;
              done       <= 1'b1;
              busy       <= 1'b0;
              byte_ready <= 1'b0;
              cpu_hold   <= 1'b0;
            end else if (int'(pk_len) > MAX_WORDS) begin
              // Oversize images are rejected before any write so memory stays intact.
              state      <= DONE;
              err        <= 1'b1;
              busy       <= 1'b0;
              byte_ready <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (pk_word_last) begin
            state      <= WRITE;
            we         <= 1'b1;
            wdata      <= Width'(pk_word);
            byte_ready <= 1'b0;
          end
        end
        WRITE: begin
          if (word_idx == n_words - 16'd1) begin
            state    <= DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
          end else begin
            state      <= DATA;
            word_idx   <= word_idx + 16'd1;
            waddr      <= waddr + Width'(ADDR_STEP);
            byte_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a frame-level model
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tx_q[$];
  logic [31:0] exp_words[$];
  logic [63:0] obs[$];
  logic        prev_we = 1'b0;

  imem_loader #(.Width(32), .Depth(512)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cpu_hold   (cpu_hold)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we) obs.push_back({waddr, wdata});
    if (prev_we) begin
      checks++;
      if (we !== 1'b0) begin
        errors++;
        $display("FAIL we_consecutive: we=%b required 0 after a write cycle", we);
      end
    end
    prev_we = we;
  end

  // Frame model: length N little-endian, then each word least-significant byte first.
  task automatic build_frame(input int n, input bit rnd);
    tx_q.delete();
    exp_words.delete();
    tx_q.push_back(8'(n));
    tx_q.push_back(8'(n >> 8));
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = rnd ? $urandom : 32'h0;
      exp_words.push_back(w);
      for (int b = 0; b < 4; b++) tx_q.push_back(8'(w >> (8 * b)));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (byte_ready) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
    end
    byte_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: byte %02h not accepted within 50 cycles", b);
    end
  endtask

  // Sends tx_q; after each 4th data byte the write must appear in the very next cycle.
  task automatic send_frame(input int max_stall, input int start_at);
    int k;
    k = 0;
    for (int i = 0; i < tx_q.size(); i++) begin
      if (i == start_at) pulse_start();
      send_byte(tx_q[i]);
      if (i >= 2 && ((i - 2) % 4) == 3 && k < exp_words.size()) begin
        checks++;
        if (we !== 1'b1 || waddr !== 32'(4 * k) || wdata !== exp_words[k]) begin
          errors++;
          $display("FAIL write_latency: we=%b waddr=%0d wdata=%08h required we=1 waddr=%0d wdata=%08h",
                   we, waddr, wdata, 4 * k, exp_words[k]);
        end
        k++;
      end
      if (max_stall > 0) repeat ($urandom_range(max_stall, max_stall == 3 ? 3 : 0)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic finish_and_compare(input string name);
    int c;
    c = 0;
    while (!(done || err) && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    @(posedge clk); #1;
    checks++;
    if (obs.size() != exp_words.size()) begin
      errors++;
      $display("FAIL %s_count: writes=%0d required %0d", name, obs.size(), exp_words.size());
    end else begin
      for (int i = 0; i < exp_words.size(); i++) begin
        checks++;
        if (obs[i] !== {32'(4 * i), exp_words[i]}) begin
          errors++;
          $display("FAIL %s_write%0d: got %016h required %016h", name, i, obs[i], {32'(4 * i), exp_words[i]});
        end
      end
    end
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_final: done=%b err=%b busy=%b cpu_hold=%b byte_ready=%b required 1 0 0 0 0",
               name, done, err, busy, cpu_hold, byte_ready);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (byte_ready !== 1'b0 || we !== 1'b0 || waddr !== 32'h0 || wdata !== 32'h0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL %s: ready=%b we=%b waddr=%h wdata=%h busy=%b done=%b err=%b hold=%b required 0 0 0 0 0 0 0 1",
               name, byte_ready, we, waddr, wdata, busy, done, err, cpu_hold);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_values("reset_values");
  endtask

  task automatic test_two_word();
    obs.delete();
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h02, 8'h21, 8'h00, 8'h83, 8'h82, 8'hD1, 8'h00};
    exp_words = '{32'h00210213, 32'h00D18283};
    pulse_start();
    checks++;
    if (busy !== 1'b1 || byte_ready !== 1'b1 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL start_response: busy=%b byte_ready=%b cpu_hold=%b required 1 1 1", busy, byte_ready, cpu_hold);
    end
    send_frame(0, -1);
    finish_and_compare("two_word");
  endtask

  task automatic test_stalls();
    obs.delete();
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h02, 8'h21, 8'h00, 8'h83, 8'h82, 8'hD1, 8'h00};
    exp_words = '{32'h00210213, 32'h00D18283};
    pulse_start();
    send_frame(3, -1);
    finish_and_compare("stalls");
  endtask

  task automatic test_random_frames();
    for (int t = 0; t < 4; t++) begin
      obs.delete();
      build_frame($urandom_range(6, 1), 1'b1);
      pulse_start();
      send_frame(2, -1);
      finish_and_compare("random");
    end
  endtask

  task automatic test_empty_oversize();
    obs.delete();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL empty_frame: done=%b err=%b busy=%b byte_ready=%b required 1 0 0 0", done, err, busy, byte_ready);
    end
    pulse_start();
    send_byte(8'h81);
    send_byte(8'h00);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL oversize_frame: err=%b done=%b busy=%b cpu_hold=%b required 1 0 0 1", err, done, busy, cpu_hold);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs.size() != 0 || err !== 1'b1 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL no_write_frames: writes=%0d err=%b cpu_hold=%b required 0 1 1", obs.size(), err, cpu_hold);
    end
  endtask

  task automatic test_full_capacity();
    obs.delete();
    build_frame(128, 1'b1);
    pulse_start();
    checks++;
    if (err !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_clears_flags: err=%b done=%b required 0 0", err, done);
    end
    send_frame(0, 300);
    finish_and_compare("full");
    checks++;
    if (obs.size() == 128 && obs[127][63:32] !== 32'd508) begin
      errors++;
      $display("FAIL full_last_addr: waddr=%0d required 508", obs[127][63:32]);
    end
  endtask

  task automatic test_reset_mid_word();
    obs.delete();
    build_frame(2, 1'b1);
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(tx_q[i]);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_values("reset_mid_word");
    build_frame(1, 1'b1);
    pulse_start();
    send_frame(0, -1);
    finish_and_compare("after_reset");
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_stalls();
    test_random_frames();
    test_empty_oversize();
    test_full_capacity();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
